// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPU_OWN,
    EXT_BURST,
    EXT_DRAIN
  } arb_state_t;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_MAX_WAIT = 16;
  localparam int unsigned DEF_LEN_W    = 8;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of cycles a pending external request has been refused.
module arb_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic at_limit
);

  localparam int unsigned CW = cnt_width(MAX_WAIT);

  logic [CW-1:0] cnt;

  assign at_limit = (cnt == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between CPU load/store and an external burst reader.
// Optional stall-cycle counter built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
  parameter int unsigned LEN_W    = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [LEN_W-1:0]  ext_len,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              ext_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_count
);

  arb_state_t        state, state_nx;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  idx, last_idx;
  logic              ext_rvalid_q, ext_done_q, cpu_rvalid_q;
  logic              gnt, cpu_acc, burst_rd, burst_last;
  logic              wc_clear, wc_inc, wc_at_limit;

  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .clear    (wc_clear),
    .inc      (wc_inc),
    .at_limit (wc_at_limit)
  );

  // Memory-side outputs are gated while reset is low so reset dominates the CPU inputs.
  always_comb begin
    state_nx   = state;
    gnt        = 1'b0;
    cpu_acc    = 1'b0;
    burst_rd   = 1'b0;
    burst_last = 1'b0;
    wc_clear   = 1'b0;
    wc_inc     = 1'b0;
    cpu_stall  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (reset) begin
      unique case (state)
        EXT_BURST: begin
          burst_rd   = 1'b1;
          burst_last = (idx == last_idx);
          mem_addr   = base + ADDR_W'(idx);
          cpu_stall  = cpu_req;
          wc_clear   = !ext_req;
          if (burst_last) state_nx = EXT_DRAIN;
        end
        default: begin
          if (ext_req && (!cpu_req || wc_at_limit)) begin
            gnt       = 1'b1;
            cpu_stall = 1'b1;
            wc_clear  = 1'b1;
            state_nx  = EXT_BURST;
          end else begin
            wc_clear = !ext_req;
            wc_inc   = ext_req;
            if (cpu_req) begin
              cpu_acc   = 1'b1;
              mem_we    = cpu_we;
              mem_addr  = cpu_addr;
              mem_wdata = cpu_wdata;
              state_nx  = CPU_OWN;
            end else begin
              state_nx = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      base         <= '0;
      idx          <= '0;
      last_idx     <= '0;
      ext_rvalid_q <= 1'b0;
      ext_done_q   <= 1'b0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      state        <= state_nx;
      ext_rvalid_q <= burst_rd;
      ext_done_q   <= burst_last;
      cpu_rvalid_q <= cpu_acc && !cpu_we;
      if (gnt) begin
        base     <= ext_addr;
        idx      <= '0;
        last_idx <= (ext_len == '0) ? '0 : ext_len - LEN_W'(1);
      end else if (burst_rd) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign ext_gnt    = gnt;
  assign ext_rvalid = ext_rvalid_q;
  assign ext_done   = ext_done_q;
  assign ext_rdata  = ext_rvalid_q ? mem_rdata : '0;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (cpu_req && cpu_stall && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule
